// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for R-type, lw, sw, beq, addi and j, and counts retired instructions.
module mips_multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        i_or_d,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [3:0]  state,
  output logic        trap,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr_count;
  logic [3:0]  r_alu_hold;
  logic [3:0]  w_funct_alu;
  logic        w_funct_ok;
  logic        w_retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_instr_count <= 32'd0;
      r_alu_hold    <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
      if (r_state == S_EXEC) r_alu_hold <= w_funct_alu;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = 4'd0;
    case (funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_TRAP;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP:   w_next = S_TRAP;
      // Unused codes recover to FETCH without counting a retirement.
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    i_or_d      = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 4'd0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    trap        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_funct_alu;
      end
      S_ALUWB: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        alu_control = r_alu_hold;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed, table-driven bench for the multicycle MIPS controller, with
// hand-written sequences for memory waits, traps, mid-wait reset and count wrap.
module tb_mips_multicycle_controller;

  logic        clk, reset, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        mem_req, i_or_d, mem_write, ir_write, pc_en;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, trap;
  logic [3:0]  alu_control, state;
  logic [31:0] instr_count;

  int n_pass = 0;
  int n_total = 0;

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d),
    .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .state(state), .trap(trap),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010;
  localparam logic [5:0] F_OR = 6'b100101, F_BAD = 6'b111111;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111, OR_ = 4'b0001;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zr;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // {mem_req,i_or_d,mem_write,ir_write,pc_en,pc_src,alu_src_a,alu_src_b,alu_control,reg_dst,mem_to_reg,reg_write,trap}
  function automatic logic [17:0] ec(input logic mreq, iod, mw, irw, pce,
                                     input logic [1:0] psrc, input logic a,
                                     input logic [1:0] b, input logic [3:0] alu,
                                     input logic rd, m2r, rw, tr);
    return {mreq, iod, mw, irw, pce, psrc, a, b, alu, rd, m2r, rw, tr};
  endfunction

  function automatic logic [17:0] c_fetch(input logic rdy);
    return ec(1, 0, 0, rdy, rdy, 2'b00, 0, 2'b01, ADD, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] c_dec();    return ec(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0); endfunction
  function automatic logic [17:0] c_exec(input logic [3:0] alu);
    return ec(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, alu, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] c_aluwb(input logic [3:0] alu);
    return ec(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, alu, 1, 0, 1, 0);
  endfunction
  function automatic logic [17:0] c_imm();    return ec(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0); endfunction
  function automatic logic [17:0] c_memrd();  return ec(1,1,0,0,0,2'b00,0,2'b00,4'd0,0,0,0,0); endfunction
  function automatic logic [17:0] c_memwb();  return ec(0,0,0,0,0,2'b00,0,2'b00,4'd0,0,1,1,0); endfunction
  function automatic logic [17:0] c_memwr();  return ec(1,1,1,0,0,2'b00,0,2'b00,4'd0,0,0,0,0); endfunction
  function automatic logic [17:0] c_branch(input logic z);
    return ec(0, 0, 0, 0, z, 2'b01, 1, 2'b00, SUB, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] c_addiwb(); return ec(0,0,0,0,0,2'b00,0,2'b00,4'd0,0,0,1,0); endfunction
  function automatic logic [17:0] c_jump();   return ec(0,0,0,0,1,2'b10,0,2'b00,4'd0,0,0,0,0); endfunction
  function automatic logic [17:0] c_trap();   return ec(0,0,0,0,0,2'b00,0,2'b00,4'd0,0,0,0,1); endfunction

  function automatic logic [17:0] act_ctl();
    return {mem_req, i_or_d, mem_write, ir_write, pc_en, pc_src, alu_src_a,
            alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, trap};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called #1 after a rising edge: drive, let outputs settle, compare, advance.
  task automatic run(input string tag, input logic [5:0] op, fn, input logic zr, rdy,
                     input logic [3:0] st, input logic [17:0] ctl, input logic [31:0] cnt);
    opcode = op; funct = fn; zero = zr; mem_ready = rdy;
    #2;
    check({tag, " state"}, {28'd0, state}, {28'd0, st});
    check({tag, " ctl"}, {14'd0, act_ctl()}, {14'd0, ctl});
    check({tag, " count"}, instr_count, cnt);
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic [5:0] op, fn, input logic rdy);
    opcode = op; funct = fn; zero = 1'b0; mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    vecs.push_back('{OP_R, F_ADD, 0, 1, 4'd0, c_fetch(1), 0});
    vecs.push_back('{OP_R, F_ADD, 0, 1, 4'd1, c_dec(), 0});
    vecs.push_back('{OP_R, F_ADD, 0, 1, 4'd6, c_exec(ADD), 0});
    vecs.push_back('{OP_R, F_ADD, 0, 1, 4'd7, c_aluwb(ADD), 0});
    vecs.push_back('{OP_R, F_SUB, 0, 1, 4'd0, c_fetch(1), 1});
    vecs.push_back('{OP_R, F_SUB, 0, 1, 4'd1, c_dec(), 1});
    vecs.push_back('{OP_R, F_SUB, 0, 1, 4'd6, c_exec(SUB), 1});
    vecs.push_back('{OP_R, F_SUB, 0, 1, 4'd7, c_aluwb(SUB), 1});
    vecs.push_back('{OP_R, F_SLT, 0, 1, 4'd0, c_fetch(1), 2});
    vecs.push_back('{OP_R, F_SLT, 0, 1, 4'd1, c_dec(), 2});
    vecs.push_back('{OP_R, F_SLT, 0, 1, 4'd6, c_exec(SLT), 2});
    vecs.push_back('{OP_R, F_SLT, 0, 1, 4'd7, c_aluwb(SLT), 2});
    vecs.push_back('{OP_ADDI, F_OR, 0, 1, 4'd0, c_fetch(1), 3});
    vecs.push_back('{OP_ADDI, F_OR, 0, 1, 4'd1, c_dec(), 3});
    vecs.push_back('{OP_ADDI, F_OR, 0, 1, 4'd9, c_imm(), 3});
    vecs.push_back('{OP_ADDI, F_OR, 0, 1, 4'd10, c_addiwb(), 3});
    vecs.push_back('{OP_SW, F_ADD, 0, 0, 4'd0, c_fetch(0), 4});
    vecs.push_back('{OP_SW, F_ADD, 0, 1, 4'd0, c_fetch(1), 4});
    vecs.push_back('{OP_SW, F_ADD, 0, 1, 4'd1, c_dec(), 4});
    vecs.push_back('{OP_SW, F_ADD, 0, 1, 4'd2, c_imm(), 4});
    vecs.push_back('{OP_SW, F_ADD, 0, 0, 4'd5, c_memwr(), 4});
    vecs.push_back('{OP_SW, F_ADD, 0, 1, 4'd5, c_memwr(), 4});
    vecs.push_back('{OP_BEQ, F_ADD, 1, 1, 4'd0, c_fetch(1), 5});
    vecs.push_back('{OP_BEQ, F_ADD, 1, 1, 4'd1, c_dec(), 5});
    vecs.push_back('{OP_BEQ, F_ADD, 1, 1, 4'd8, c_branch(1), 5});
    vecs.push_back('{OP_BEQ, F_ADD, 0, 1, 4'd0, c_fetch(1), 6});
    vecs.push_back('{OP_BEQ, F_ADD, 0, 1, 4'd1, c_dec(), 6});
    vecs.push_back('{OP_BEQ, F_ADD, 0, 1, 4'd8, c_branch(0), 6});
    vecs.push_back('{OP_J, F_ADD, 0, 1, 4'd0, c_fetch(1), 7});
    vecs.push_back('{OP_J, F_ADD, 0, 1, 4'd1, c_dec(), 7});
    vecs.push_back('{OP_J, F_ADD, 0, 1, 4'd11, c_jump(), 7});
    vecs.push_back('{OP_J, F_ADD, 0, 0, 4'd0, c_fetch(0), 8});

    for (int i = 0; i < vecs.size(); i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].zr, vecs[i].rdy,
          vecs[i].st, vecs[i].ctl, vecs[i].cnt);

    // lw with three wait cycles in MEMRD: 8 cycles total
    run("lw F", OP_LW, F_ADD, 0, 1, 4'd0, c_fetch(1), 8);
    run("lw D", OP_LW, F_ADD, 0, 1, 4'd1, c_dec(), 8);
    run("lw ADR", OP_LW, F_ADD, 0, 1, 4'd2, c_imm(), 8);
    for (int w = 0; w < 3; w++)
      run($sformatf("lw wait%0d", w), OP_LW, F_ADD, 0, 0, 4'd3, c_memrd(), 8);
    run("lw RD", OP_LW, F_ADD, 0, 1, 4'd3, c_memrd(), 8);
    run("lw WB", OP_LW, F_ADD, 0, 1, 4'd4, c_memwb(), 8);
    run("lw done", OP_LW, F_ADD, 0, 0, 4'd0, c_fetch(0), 9);

    // Illegal opcode: trap is sticky until reset
    run("bad F", OP_BAD, F_ADD, 0, 1, 4'd0, c_fetch(1), 9);
    run("bad D", OP_BAD, F_ADD, 0, 1, 4'd1, c_dec(), 9);
    for (int t = 0; t < 10; t++)
      run($sformatf("trap%0d", t), OP_BAD, F_ADD, 0, 1, 4'd12, c_trap(), 9);
    do_reset();
    run("trap rst", OP_R, F_ADD, 0, 0, 4'd0, c_fetch(0), 0);

    // Unsupported funct traps from EXEC
    tick(OP_R, F_BAD, 1);
    tick(OP_R, F_BAD, 1);
    tick(OP_R, F_BAD, 1);
    run("bad funct", OP_R, F_BAD, 0, 1, 4'd12, c_trap(), 0);
    do_reset();

    // Retire one j, then reset in the middle of a sw wait
    tick(OP_J, F_ADD, 1);
    tick(OP_J, F_ADD, 1);
    tick(OP_J, F_ADD, 1);
    tick(OP_SW, F_ADD, 1);
    tick(OP_SW, F_ADD, 1);
    tick(OP_SW, F_ADD, 1);
    run("sw wait", OP_SW, F_ADD, 0, 0, 4'd5, c_memwr(), 1);
    reset = 1'b1;
    #2;
    check("rst mem_write", {31'd0, mem_write}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run("after rst", OP_J, F_ADD, 0, 0, 4'd0, c_fetch(0), 0);

    // Count wrap: preload all-ones, then retire a j
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1 release dut.r_instr_count;
    run("wrap F", OP_J, F_ADD, 0, 1, 4'd0, c_fetch(1), 32'hFFFF_FFFF);
    run("wrap D", OP_J, F_ADD, 0, 1, 4'd1, c_dec(), 32'hFFFF_FFFF);
    run("wrap J", OP_J, F_ADD, 0, 1, 4'd11, c_jump(), 32'hFFFF_FFFF);
    run("wrap done", OP_J, F_ADD, 0, 0, 4'd0, c_fetch(0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward.
- funct  in  6  instruction register bits [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  shared memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- pc_en  out  1  PC load.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 00}.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_control  out  4  ALU operation: 0010 = add, 0110 = sub, 0000 = and, 0001 = or, 0111 = slt.
- reg_dst  out  1  register write address select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- state  out  4  current FSM state, for debug.
- trap  out  1  illegal-opcode halt flag.
- instr_count  out  32  count of retired instructions.

Function
REQ-003 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12; codes 13-15 SHALL go to FETCH on the next cycle.

REQ-004 FETCH outputs SHALL be: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00. ir_write and pc_en SHALL be 1 only in the cycle mem_ready=1. The FSM SHALL leave FETCH for DECODE only in that cycle.

REQ-005 DECODE outputs SHALL be: alu_src_a=0, alu_src_b=11, alu_control=add. DECODE SHALL branch on opcode:
- 000000 (R-type) -> EXEC.
- 100011 (lw) or 101011 (sw) -> MEMADR.
- 000100 (beq) -> BRANCH.
- 001000 (addi) -> ADDIEX.
- 000010 (j) -> JUMP.
- any other opcode -> TRAP.

REQ-006 MEMADR outputs SHALL be: alu_src_a=1, alu_src_b=10, alu_control=add. Next state SHALL be MEMRD for lw and MEMWR for sw.

REQ-007 MEMRD SHALL drive mem_req=1 and i_or_d=1. It SHALL hold until mem_ready=1, then go to MEMWB.

REQ-008 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.

REQ-009 MEMWR SHALL drive mem_req=1 and i_or_d=1. mem_write SHALL be 1 throughout the wait. The FSM SHALL go to FETCH in the cycle mem_ready=1.

REQ-010 EXEC SHALL drive alu_src_a=1 and alu_src_b=00. alu_control SHALL decode from funct:
- 100000 -> add.
- 100010 -> sub.
- 100100 -> and.
- 100101 -> or.
- 101010 -> slt.
- other funct -> go to TRAP instead of ALUWB.

REQ-011 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, with alu_control held from EXEC.

REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_control=sub, pc_src=01, and pc_en=zero.

REQ-013 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_control=add. ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.

REQ-014 JUMP SHALL drive pc_src=10 and pc_en=1.

REQ-015 Each state's successor SHALL be:
- ALUWB, MEMWB, BRANCH, ADDIWB, JUMP, and MEMWR (when mem_ready=1) -> FETCH.
- ADDIEX -> ADDIWB.

REQ-016 Any output not listed for a state SHALL be 0.

REQ-017 While waiting on mem_ready, every output SHALL hold constant.

REQ-018 TRAP SHALL drive trap=1 and all enables 0, and SHALL remain in TRAP until reset.

REQ-019 instr_count SHALL increment by 1 on each transition into FETCH from a completing state. It SHALL wrap from 0xFFFFFFFF to 0. It SHALL NOT increment when leaving TRAP or an unused state code.

REQ-020 Latency in cycles, assuming mem_ready is always 1, SHALL be:
- R-type and addi: 4.
- lw: 5.
- sw: 4.
- beq and j: 3.

Reset
REQ-021 With reset=1 at a clock edge, the block SHALL set state=FETCH, instr_count=0, trap=0, regardless of current state, including mid-wait.

REQ-022 While reset=1, pc_en, ir_write, reg_write, mem_write and mem_req SHALL be forced to 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then R-type add (funct 100000) with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7; instr_count=1.
- lw with mem_ready low for 3 cycles in MEMRD -> state holds at 3 for 4 cycles with i_or_d=1 and mem_req=1; then 4,0; total 8 cycles.
- beq with zero=1 and then with zero=0 -> pc_en=1 in BRANCH only in the zero=1 case; pc_src=01 in both.
- Opcode 111111 in DECODE -> TRAP, trap=1; stays 10 cycles; instr_count unchanged; reset -> FETCH, trap=0.
- Reset asserted during MEMWR wait -> next state FETCH; mem_write=0 in the reset cycle; instr_count=0.
- Preload instr_count to 0xFFFFFFFF via a j sequence -> wraps to 0 on the next retire.
